// File: rtl/sync_counter.sv
// sync_counter: fully synchronous modulo counter with enable, clamped
// parallel load, programmable terminal value, cascade carry and wrap flag.
//
// Parameters:
//   WIDTH   - counter width in bits (>= 1)
//   MAX     - terminal value, highest count reached (1 .. 2**WIDTH-1)
//   RST_VAL - count after reset (<= MAX)
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   count enable
//   up       in   direction (1 = up); only used with COUNTER_UPDOWN_EN
//   load     in   parallel load strobe, overrides en
//   load_val in   value to load, clamped to MAX
//   count    out  registered count
//   tc       out  combinational terminal-count carry for cascading
//   wrap     out  registered one-cycle pulse after the count wrapped
//
// Build option:
//   COUNTER_UPDOWN_EN - when defined, `up` selects the direction per
//   cycle; otherwise the counter is up-only and `up` is ignored.

module sync_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX     = (2 ** WIDTH) - 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ZERO  = '0;

    logic             at_max;
    logic             at_term;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamp;

    assign at_max = (count == MAX_C);

`ifdef COUNTER_UPDOWN_EN
    logic at_zero;
    logic inc_val_sel;

    assign at_zero     = (count == ZERO);
    assign inc_val_sel = up;

    // Terminal value depends on direction: MAX going up, 0 going down.
    assign at_term = inc_val_sel ? at_max : at_zero;

    always_comb begin
        step_val = count;
        if (inc_val_sel) begin
            step_val = at_max ? ZERO : count + 1'b1;
        end else begin
            step_val = at_zero ? MAX_C : count - 1'b1;
        end
    end
`else
    logic unused_up;

    assign unused_up = up;
    assign at_term   = at_max;

    always_comb begin
        step_val = count;
        step_val = at_max ? ZERO : count + 1'b1;
    end
`endif

    // Clamping the load keeps the count inside 0..MAX, so the step
    // logic never has to handle out-of-range values.
    assign load_clamp = (load_val > MAX_C) ? MAX_C : load_val;

    // Carry is qualified by rst and load so it is high only in the
    // cycle whose edge really wraps the counter.
    assign tc = en & ~load & ~rst & at_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_C;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamp;
            wrap  <= 1'b0;
        end else if (en) begin
            count <= step_val;
            wrap  <= at_term;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule
